// File: rtl/ctrl_unit.sv
// ctrl_unit: fetch/decode/sequence controller driving the 16-bit datapath control side.
// Every output is a register updated together with the state, so strobes are glitch-free.
module ctrl_unit #(
    parameter int DWIDTH  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DWIDTH-1:0] ins_data,
    input  logic              ins_ack,
    output logic              ins_req,
    output logic              dp_en_in,
    input  logic              dp_done,
    output logic              en_pc_pulse,
    output logic [1:0]        pc_ctrl,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic [3:0]        reg_en,
    output logic [2:0]        alu_func,
    output logic              alu_in_sel,
    output logic              ldr_sel,
    output logic [7:0]        offset,
    output logic [7:0]        offset_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              halted,
    output logic              err
);
    typedef enum logic [3:0] {
        IDLE, CLR, FETCH, DECODE, EXEC, WAIT, MEM, WB, JUMP, NEXT, HALT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [DWIDTH-1:0] ir;
    logic [7:0]        cnt;
    logic [3:0]        op;
    logic              is_alu;
    logic [2:0]        func;
    logic              timeout;

    assign op      = ir[15:12];
    assign is_alu  = op >= 4'd1 && op <= 4'd5;
    // ADD/SUB/AND/OR map straight from the opcode; ADDI adds; non-ALU ops pass B through
    assign func    = (op >= 4'd1 && op <= 4'd4) ? 3'(op - 4'd1) : (op == 4'd5 ? 3'b000 : 3'b100);
    assign timeout = cnt == CNT_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ir          <= '0;
            cnt         <= '0;
            ins_req     <= 1'b0;
            dp_en_in    <= 1'b0;
            en_pc_pulse <= 1'b0;
            pc_ctrl     <= 2'b00;
            rd          <= 2'b00;
            rs          <= 2'b00;
            reg_en      <= 4'b0000;
            alu_func    <= 3'b000;
            alu_in_sel  <= 1'b0;
            ldr_sel     <= 1'b0;
            offset      <= 8'h00;
            offset_addr <= 8'h00;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state       <= CLR;
                        en_pc_pulse <= 1'b1;
                        pc_ctrl     <= 2'b11;
                        halted      <= 1'b0;
                    end
                end
                CLR, JUMP, NEXT: begin
                    state       <= FETCH;
                    en_pc_pulse <= 1'b0;
                    pc_ctrl     <= 2'b00;
                    ins_req     <= 1'b1;
                    cnt         <= '0;
                end
                FETCH: begin
                    if (ins_ack) begin
                        state   <= DECODE;
                        ir      <= ins_data;
                        ins_req <= 1'b0;
                    end else if (timeout) begin
                        state   <= HALT;
                        ins_req <= 1'b0;
                        halted  <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DECODE: begin
                    rd          <= ir[11:10];
                    rs          <= ir[9:8];
                    offset      <= ir[7:0];
                    offset_addr <= ir[7:0];
                    alu_func    <= func;
                    alu_in_sel  <= op == 4'd5;
                    ldr_sel     <= op == 4'd6;
                    cnt         <= '0;
                    if (is_alu) begin
                        state    <= EXEC;
                        dp_en_in <= 1'b1;
                    end else if (op == 4'd6) begin
                        state  <= MEM;
                        mem_rd <= 1'b1;
                    end else if (op == 4'd7) begin
                        state  <= MEM;
                        mem_wr <= 1'b1;
                    end else if (op == 4'd8) begin
                        state       <= JUMP;
                        en_pc_pulse <= 1'b1;
                        pc_ctrl     <= 2'b10;
                    end else if (op == 4'hF) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state       <= NEXT;
                        en_pc_pulse <= 1'b1;
                        pc_ctrl     <= 2'b01;
                    end
                end
                EXEC: begin
                    state    <= WAIT;
                    dp_en_in <= 1'b0;
                    cnt      <= '0;
                end
                WAIT: begin
                    if (dp_done) begin
                        state  <= WB;
                        reg_en <= 4'b0001 << rd;
                    end else if (timeout) begin
                        state  <= HALT;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (mem_rd) begin
                            state  <= WB;
                            reg_en <= 4'b0001 << rd;
                        end else begin
                            state       <= NEXT;
                            en_pc_pulse <= 1'b1;
                            pc_ctrl     <= 2'b01;
                        end
                    end else if (timeout) begin
                        state  <= HALT;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WB: begin
                    state       <= NEXT;
                    reg_en      <= 4'b0000;
                    en_pc_pulse <= 1'b1;
                    pc_ctrl     <= 2'b01;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: table-driven instruction vectors plus hand-written multi-cycle corner cases.
module tb_ctrl_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] ins_data;
    logic        ins_ack;
    logic        ins_req;
    logic        dp_en_in;
    logic        dp_done;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  reg_en;
    logic [2:0]  alu_func;
    logic        alu_in_sel;
    logic        ldr_sel;
    logic [7:0]  offset;
    logic [7:0]  offset_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic        halted;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    ctrl_unit #(.DWIDTH(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ins_data(ins_data), .ins_ack(ins_ack),
        .ins_req(ins_req), .dp_en_in(dp_en_in), .dp_done(dp_done),
        .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl), .rd(rd), .rs(rs), .reg_en(reg_en),
        .alu_func(alu_func), .alu_in_sel(alu_in_sel), .ldr_sel(ldr_sel), .offset(offset),
        .offset_addr(offset_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] ins;
        int          lat;
        logic [1:0]  rd;
        logic [1:0]  rs;
        logic        chk_func;
        logic [2:0]  func;
        logic        insel;
        logic        ldr;
        logic [7:0]  off;
        int          dp;
        logic [3:0]  wb;
        int          nrd;
        int          nwr;
        logic [1:0]  pc;
    } vec_t;

    vec_t vecs [10];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, ins_req, dp_en_in, en_pc_pulse, pc_ctrl, rd, rs, reg_en, alu_func,
                alu_in_sel, ldr_sel, offset, offset_addr, mem_rd, mem_wr, halted, err};
    endfunction

    task automatic fetch(input logic [15:0] w);
        check("fetch_req", ins_req, 1'b1);
        ins_data = w;
        ins_ack  = 1'b1;
        step;
        ins_ack  = 1'b0;
        ins_data = '0;
    endtask

    // Runs one instruction from FETCH to the next FETCH with modelled datapath/memory responders.
    task automatic run_vec(input vec_t v);
        int dp_n = 0, wb_n = 0, rd_n = 0, wr_n = 0, pc_n = 0, dcnt = 0, age = 0;
        logic [3:0] wb_v = '0;
        logic [1:0] pc_v = '0;
        fetch(v.ins);
        check({v.name, "_decode_req"}, ins_req, 1'b0);
        step;
        check({v.name, "_rd"}, rd, v.rd);
        check({v.name, "_rs"}, rs, v.rs);
        if (v.chk_func) check({v.name, "_func"}, alu_func, v.func);
        check({v.name, "_insel"}, alu_in_sel, v.insel);
        check({v.name, "_ldrsel"}, ldr_sel, v.ldr);
        check({v.name, "_off"}, offset, v.off);
        check({v.name, "_offaddr"}, offset_addr, v.off);
        for (int c = 0; c < 40; c++) begin
            if (ins_req) break;
            dp_done = 1'b0;
            mem_ack = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                dp_done = dcnt == 0;
            end
            if (dp_en_in) begin
                dp_n++;
                dcnt = 3;
            end
            if (reg_en != 4'b0000) begin
                wb_n++;
                wb_v = reg_en;
            end
            if (mem_rd) rd_n++;
            if (mem_wr) wr_n++;
            if (mem_rd || mem_wr) begin
                age++;
                mem_ack = age > v.lat;
            end
            if (en_pc_pulse) begin
                pc_n++;
                pc_v = pc_ctrl;
            end
            step;
        end
        dp_done = 1'b0;
        mem_ack = 1'b0;
        check({v.name, "_refetch"}, ins_req, 1'b1);
        check({v.name, "_dp_cycles"}, dp_n, v.dp);
        check({v.name, "_wb_cycles"}, wb_n, (v.wb != 4'b0000) ? 1 : 0);
        check({v.name, "_reg_en"}, wb_v, v.wb);
        check({v.name, "_rd_cycles"}, rd_n, v.nrd);
        check({v.name, "_wr_cycles"}, wr_n, v.nwr);
        check({v.name, "_pc_cycles"}, pc_n, 1);
        check({v.name, "_pc_ctrl"}, pc_v, v.pc);
    endtask

    initial begin
        vecs[0] = '{"add",   16'h1600, 0, 2'd1, 2'd2, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 1, 4'b0010, 0, 0, 2'b01};
        vecs[1] = '{"sub",   16'h2300, 0, 2'd0, 2'd3, 1'b1, 3'b001, 1'b0, 1'b0, 8'h00, 1, 4'b0001, 0, 0, 2'b01};
        vecs[2] = '{"and",   16'h3900, 0, 2'd2, 2'd1, 1'b1, 3'b010, 1'b0, 1'b0, 8'h00, 1, 4'b0100, 0, 0, 2'b01};
        vecs[3] = '{"or",    16'h4C00, 0, 2'd3, 2'd0, 1'b1, 3'b011, 1'b0, 1'b0, 8'h00, 1, 4'b1000, 0, 0, 2'b01};
        vecs[4] = '{"addi",  16'h5C2A, 0, 2'd3, 2'd0, 1'b1, 3'b000, 1'b1, 1'b0, 8'h2A, 1, 4'b1000, 0, 0, 2'b01};
        vecs[5] = '{"ldr",   16'h6010, 2, 2'd0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b1, 8'h10, 0, 4'b0001, 3, 0, 2'b01};
        vecs[6] = '{"str",   16'h7244, 1, 2'd0, 2'd2, 1'b0, 3'b000, 1'b0, 1'b0, 8'h44, 0, 4'b0000, 0, 2, 2'b01};
        vecs[7] = '{"jmp",   16'h8080, 0, 2'd0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h80, 0, 4'b0000, 0, 0, 2'b10};
        vecs[8] = '{"nop",   16'h0000, 0, 2'd0, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 0, 4'b0000, 0, 0, 2'b01};
        vecs[9] = '{"undef", 16'h9123, 0, 2'd0, 2'd1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h23, 0, 4'b0000, 0, 0, 2'b01};

        rst = 1'b1; start = 1'b0; ins_data = '0; ins_ack = 1'b0; dp_done = 1'b0; mem_ack = 1'b0;
        step;
        step;
        check("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        step;
        check("idle_outs", all_outs(), 64'd0);

        start = 1'b1;
        step;
        start = 1'b0;
        check("clr_pulse", en_pc_pulse, 1'b1);
        check("clr_pc_ctrl", pc_ctrl, 2'b11);
        check("clr_no_req", ins_req, 1'b0);
        step;
        check("fetch_pulse_low", en_pc_pulse, 1'b0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Stray dp_done/mem_ack during DECODE must not skip the WAIT state.
        fetch(16'h1600);
        dp_done = 1'b1;
        mem_ack = 1'b1;
        step;
        dp_done = 1'b0;
        mem_ack = 1'b0;
        check("stray_exec_pulse", dp_en_in, 1'b1);
        check("stray_exec_reg_en", reg_en, 4'b0000);
        step;
        check("stray_wait_reg_en", reg_en, 4'b0000);
        check("stray_wait_dp_en", dp_en_in, 1'b0);
        dp_done = 1'b1;
        step;
        dp_done = 1'b0;
        check("stray_wb_reg_en", reg_en, 4'b0010);
        step;
        check("stray_next_reg_en", reg_en, 4'b0000);
        check("stray_next_pc", {en_pc_pulse, pc_ctrl}, 3'b101);
        step;

        // dp_done withheld: err and halted after TIMEOUT cycles of WAIT.
        fetch(16'h1600);
        step;
        check("to_exec", dp_en_in, 1'b1);
        step;
        begin
            int n = 0;
            while (!err && n < 20) begin
                step;
                n++;
            end
            check("to_cycles", n, 8);
        end
        check("to_halted", halted, 1'b1);
        check("to_strobes", {ins_req, dp_en_in, en_pc_pulse, reg_en, mem_rd, mem_wr}, 9'd0);

        start = 1'b1;
        step;
        start = 1'b0;
        check("restart_clr", {en_pc_pulse, pc_ctrl, halted}, 4'b1110);
        check("err_sticky", err, 1'b1);
        step;

        // HALT instruction, then restart.
        fetch(16'hF000);
        step;
        step;
        check("halt_halted", halted, 1'b1);
        check("halt_strobes", {ins_req, dp_en_in, en_pc_pulse, reg_en, mem_rd, mem_wr}, 9'd0);
        step;
        step;
        check("halt_stays", {halted, ins_req}, 2'b10);
        start = 1'b1;
        step;
        start = 1'b0;
        check("halt_restart", {en_pc_pulse, pc_ctrl, halted}, 4'b1110);
        step;

        // Asynchronous reset in the middle of a memory read.
        fetch(16'h6010);
        step;
        step;
        check("mem_rd_high", mem_rd, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_mem_rd", mem_rd, 1'b0);
        check("async_outs", all_outs(), 64'd0);
        step;
        rst = 1'b0;
        step;
        check("post_rst_idle", all_outs(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
